// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one byte-wide UART transmitter
//                among NUM_REQ requesters. Sequences each byte through
//                start / wait-for-clear / inter-byte gap. UART status inputs
//                come from an unrelated clock and are synchronised here.
//  Options     : define UART_ARB_PRIO0_EN to give requester 0 strict
//                priority over the round-robin group.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_clear_req,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

`ifdef UART_ARB_PRIO0_EN
  localparam bit PRIO0_EN = 1'b1;
`else
  localparam bit PRIO0_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_ready;
  logic                r_start;
  logic [DATA_W-1:0]   r_data;
  logic [ID_W-1:0]     r_gid;
  logic                r_active;
  logic                r_err;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [TO_W-1:0]     r_to_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;

  logic                r_busy_meta;
  logic                r_busy_sync;
  logic                r_clr_meta;
  logic                r_clr_sync;
  logic                r_clr_prev;

  logic                w_clear_rise;
  logic                w_any;
  logic                w_prio_hit;
  logic [ID_W-1:0]     w_gnt;
  logic [ID_W-1:0]     w_pos;
  logic [DATA_W-1:0]   w_gnt_data;
  logic [DATA_W-1:0]   w_bytes [0:NUM_REQ-1];
  int                  w_idx;

  // Split the flat request bus into one byte lane per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Two-flop synchronisers for the UART-domain status, plus clear history
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
      r_clr_meta  <= 1'b0;
      r_clr_sync  <= 1'b0;
      r_clr_prev  <= 1'b0;
    end else begin
      r_busy_meta <= tx_busy;
      r_busy_sync <= r_busy_meta;
      r_clr_meta  <= tx_clear_req;
      r_clr_sync  <= r_clr_meta;
      r_clr_prev  <= r_clr_sync;
    end
  end

  assign w_clear_rise = r_clr_sync & ~r_clr_prev;

  // Grant selection: optional requester-0 priority, else first valid after rr_ptr
  always_comb begin
    w_any      = 1'b0;
    w_gnt      = '0;
    w_gnt_data = '0;
    w_idx      = 0;
    w_pos      = '0;
    w_prio_hit = PRIO0_EN && req_valid[0];
    if (w_prio_hit) begin
      w_any      = 1'b1;
      w_gnt      = '0;
      w_gnt_data = w_bytes[0];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_idx = int'(r_rr_ptr) + k;
        if (w_idx >= NUM_REQ) begin
          w_idx = w_idx - NUM_REQ;
        end
        w_pos = ID_W'(w_idx);
        if (!w_any && req_valid[w_pos]) begin
          w_any      = 1'b1;
          w_gnt      = w_pos;
          w_gnt_data = w_bytes[w_pos];
        end
      end
    end
  end

  // Transfer sequencer: accept, start until busy, wait for clear, gap
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= '0;
      r_start   <= 1'b0;
      r_data    <= '0;
      r_gid     <= '0;
      r_active  <= 1'b0;
      r_err     <= 1'b0;
      r_rr_ptr  <= ID_W'(NUM_REQ - 1);
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ready  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt;
            r_data   <= w_gnt_data;
            r_gid    <= w_gnt;
            // A priority grant to requester 0 leaves the rotation untouched
            if (!w_prio_hit) begin
              r_rr_ptr <= w_gnt;
            end
            r_start  <= 1'b1;
            r_to_cnt <= '0;
            r_active <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          // Busy is checked first so it wins over a same-cycle timeout
          if (r_busy_sync) begin
            r_start <= 1'b0;
            r_state <= S_WAIT;
          end else if (r_to_cnt == TO_LAST) begin
            r_start  <= 1'b0;
            r_err    <= 1'b1;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_clear_rise) begin
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign tx_start    = r_start;
  assign tx_data     = r_data;
  assign grant_id    = r_gid;
  assign active      = r_active;
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter with a UART model on
//                its own clock and a byte/grant scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int GAP_CYC   = 4;
  localparam int TO_CYC    = 100;
  localparam int BUSY_UCLK = 8;

  logic        clk;
  logic        uclk;
  logic        axis_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_clear_req;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q [$];
  logic [7:0] cap_data [0:63];
  logic [1:0] cap_id   [0:63];
  int cap_n;
  int cap_rd;
  int n_checks;
  int n_fail;
  bit uart_en;
  bit model_busy;
  int inject_req;
  int inject_done;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_W        (DATA_W),
    .GAP_CYCLES    (GAP_CYC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) u_dut (
    .axis_clk    (clk),
    .axis_rst_n  (axis_rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_clear_req(tx_clear_req),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    uclk = 1'b0;
    forever #13 uclk = ~uclk;
  end

  // Hard stop in case something wedges
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Returns at the first negedge where req_ready is non-zero, or after a budget
  task automatic wait_accept();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) return;
    end
  endtask

  // Wait for idle and compare every captured UART byte with the scoreboard
  task automatic drain(input string tag);
    int c;
    exp_t e;
    c = 0;
    while (c < 5000 && !(active == 1'b0 && !model_busy && (cap_n - cap_rd) >= exp_q.size())) begin
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_drain_done"}, 32'(c < 5000), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (cap_rd < cap_n) begin
        check_eq({tag, "_byte"}, 32'(cap_data[cap_rd % 64]), 32'(e.data));
        check_eq({tag, "_gid"},  32'(cap_id[cap_rd % 64]),   32'(e.id));
        cap_rd++;
      end else begin
        check_eq({tag, "_missing_byte"}, 32'd0, 32'd1);
      end
    end
    check_eq({tag, "_extra_bytes"}, 32'(cap_n - cap_rd), 32'd0);
  endtask

  // UART transmitter model on its own clock
  initial begin
    tx_busy      = 1'b0;
    tx_clear_req = 1'b0;
    model_busy   = 1'b0;
    inject_done  = 0;
    cap_n        = 0;
    forever begin
      @(posedge uclk);
      if (inject_done != inject_req) begin
        tx_clear_req = 1'b1;
        @(posedge uclk);
        tx_clear_req = 1'b0;
        inject_done  = inject_req;
      end else if (uart_en && tx_start) begin
        model_busy = 1'b1;
        @(posedge uclk);
        tx_busy = 1'b1;
        cap_data[cap_n % 64] = tx_data;
        cap_id[cap_n % 64]   = grant_id;
        cap_n++;
        repeat (BUSY_UCLK) @(posedge uclk);
        tx_busy = 1'b0;
        @(posedge uclk);
        tx_clear_req = 1'b1;
        @(posedge uclk);
        tx_clear_req = 1'b0;
        model_busy   = 1'b0;
      end
    end
  end

  // Main stimulus
  initial begin
    logic [3:0] oh;
    int n;
    int c;
    int prio_ord [0:3];
    n_checks   = 0;
    n_fail     = 0;
    cap_rd     = 0;
    inject_req = 0;
    uart_en    = 1'b1;
    axis_rst_n = 1'b0;
    req_valid  = 4'b0000;
    req_data   = 32'h0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready",  32'(req_ready),   32'h0);
    check_eq("rst_start",  32'(tx_start),    32'h0);
    check_eq("rst_data",   32'(tx_data),     32'h0);
    check_eq("rst_gid",    32'(grant_id),    32'h0);
    check_eq("rst_active", 32'(active),      32'h0);
    check_eq("rst_err",    32'(err_timeout), 32'h0);
    axis_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin from reset with every requester continuously valid
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) push_exp(2'(i % 4), 8'h10 + 8'(i % 4));
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_accept();
      oh = 4'b0001 << (i % 4);
      check_eq("rr_ready", 32'(req_ready), 32'(oh));
      if (i == 4) req_valid = 4'b0000;
    end
    drain("rr");

    // Single byte from requester 2
    req_data[23:16] = 8'hA5;
    push_exp(2'd2, 8'hA5);
    req_valid = 4'b0100;
    wait_accept();
    check_eq("single_ready", 32'(req_ready), 32'h4);
    check_eq("single_data",  32'(tx_data),   32'hA5);
    check_eq("single_start", 32'(tx_start),  32'h1);
    check_eq("single_gid",   32'(grant_id),  32'h2);
    check_eq("single_active", 32'(active),   32'h1);
    req_valid = 4'b0000;
    @(negedge clk);
    check_eq("single_ready_1cyc", 32'(req_ready), 32'h0);
    c = 0;
    while (c < 2000 && tx_clear_req !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    n = 0;
    c = 0;
    while (c < 200 && active) begin
      n++;
      @(negedge clk);
      c++;
    end
    check_eq("single_gap_len", 32'(n >= GAP_CYC + 2 && n <= GAP_CYC + 3), 32'd1);
    drain("single");

    // Stale clear while waiting for busy must not advance the sequencer
    uart_en = 1'b0;
    req_data[15:8] = 8'h3C;
    push_exp(2'd1, 8'h3C);
    req_valid = 4'b0010;
    wait_accept();
    check_eq("stale_ready", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    inject_req++;
    repeat (12) @(negedge clk);
    check_eq("stale_active", 32'(active),   32'h1);
    check_eq("stale_start",  32'(tx_start), 32'h1);
    uart_en = 1'b1;
    drain("stale");

    // Start timeout with busy never asserted
    uart_en = 1'b0;
    req_data[15:8] = 8'h5C;
    req_valid = 4'b0010;
    wait_accept();
    check_eq("to_ready", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    n = 0;
    c = 0;
    while (c < 500 && tx_start) begin
      n++;
      @(negedge clk);
      c++;
    end
    check_eq("to_start_len", 32'(n), 32'(TO_CYC));
    check_eq("to_err",       32'(err_timeout), 32'h1);
    check_eq("to_idle",      32'(active), 32'h0);
    repeat (5) @(negedge clk);
    check_eq("to_err_sticky", 32'(err_timeout), 32'h1);
    check_eq("to_no_reoffer", 32'(req_ready), 32'h0);
    uart_en = 1'b1;
    req_data[31:24] = 8'h77;
    push_exp(2'd3, 8'h77);
    req_valid = 4'b1000;
    wait_accept();
    check_eq("to_next_ready", 32'(req_ready), 32'h8);
    req_valid = 4'b0000;
    drain("to_next");
    check_eq("to_err_after", 32'(err_timeout), 32'h1);

    // Reset while waiting for clear
    req_data[31:24] = 8'h99;
    push_exp(2'd3, 8'h99);
    req_valid = 4'b1000;
    wait_accept();
    check_eq("rm_ready", 32'(req_ready), 32'h8);
    req_valid = 4'b0000;
    c = 0;
    while (c < 500 && tx_start) begin
      @(negedge clk);
      c++;
    end
    check_eq("rm_in_wait", 32'(active), 32'h1);
    @(negedge clk);
    #2 axis_rst_n = 1'b0;
    #1;
    check_eq("rm_start",  32'(tx_start),    32'h0);
    check_eq("rm_ready0", 32'(req_ready),   32'h0);
    check_eq("rm_active", 32'(active),      32'h0);
    check_eq("rm_err",    32'(err_timeout), 32'h0);
    check_eq("rm_data",   32'(tx_data),     32'h0);
    repeat (2) @(negedge clk);
    axis_rst_n = 1'b1;
    drain("rm");
    req_data = {8'h43, 8'h42, 8'h41, 8'h40};
    push_exp(2'd0, 8'h40);
    req_valid = 4'b1111;
    wait_accept();
    check_eq("rm_first_ready", 32'(req_ready), 32'h1);
    check_eq("rm_first_gid",   32'(grant_id),  32'h0);
    req_valid = 4'b0000;
    drain("rm_first");

    // Requester 0 joins mid-transfer
`ifdef UART_ARB_PRIO0_EN
    prio_ord = '{1, 0, 2, 3};
`else
    prio_ord = '{1, 2, 3, 0};
`endif
    req_data = {8'h23, 8'h22, 8'h21, 8'h20};
    for (int i = 0; i < 4; i++) push_exp(2'(prio_ord[i]), 8'h20 + 8'(prio_ord[i]));
    req_valid = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      wait_accept();
      oh = 4'b0001 << prio_ord[i];
      check_eq("prio_ready", 32'(req_ready), 32'(oh));
      req_valid = req_valid & ~oh;
      if (i == 0) req_valid[0] = 1'b1;
    end
    drain("prio");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
